// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 accumulator CPU.
//   ADDR_W / DATA_W : word-address and data widths
//   opcode_e        : 4-bit instruction opcodes (8..15 are executed as STP)
//   state_e         : control FSM states
//   jump_taken()    : branch decision for JMP/JGE/JNE given the current ACC
package mu0_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_STA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_JMP = 4'h4,
    OP_JGE = 4'h5,
    OP_JNE = 4'h6,
    OP_STP = 4'h7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Branch decision; ACC is the value held during DECODE.
  function automatic logic jump_taken(input opcode_e op, input logic [DATA_W-1:0] acc);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JGE:  taken = (acc[DATA_W-1] == 1'b0);
      OP_JNE:  taken = (acc != {DATA_W{1'b0}});
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_mu0_delay1.sv
// cpu_mu0_delay1: MU0 accumulator CPU for a memory with one-cycle read latency.
// Ports:
//   clk       : system clock, rising-edge
//   rst       : asynchronous active-high reset
//   running   : high until an STP (or illegal opcode) has been decoded
//   address   : 12-bit word address to memory
//   write     : store strobe (one cycle per STA)
//   read      : load strobe
//   writedata : store data (the accumulator)
//   readdata  : memory data, valid the cycle after read
// Each instruction is FETCH -> DECODE (-> EXEC for LDA/ADD/SUB). The
// instruction word is decoded straight from readdata in DECODE, so the
// operand access starts in the same cycle the IR is captured.
module cpu_mu0_delay1
  import mu0_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              running,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  state_e              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   ir_r;

  opcode_e             dec_op_s;
  logic [ADDR_W-1:0]   dec_s_s;
  opcode_e             exe_op_s;

  assign dec_op_s = opcode_e'(readdata[15:12]);
  assign dec_s_s  = readdata[ADDR_W-1:0];
  assign exe_op_s = opcode_e'(ir_r[15:12]);

  assign running   = (state_r != ST_HALTED);
  assign writedata = acc_r;

  // Memory strobes and address; DECODE outputs follow the word on readdata.
  always_comb begin
    address = pc_r;
    read    = 1'b0;
    write   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        read = 1'b1;
      end
      ST_DECODE: begin
        case (dec_op_s)
          OP_LDA, OP_ADD, OP_SUB: begin
            address = dec_s_s;
            read    = 1'b1;
          end
          OP_STA: begin
            address = dec_s_s;
            write   = 1'b1;
          end
          default: begin
            address = pc_r;
          end
        endcase
      end
      ST_EXEC: begin
        // No access; hold the operand address that was just read.
        address = ir_r[ADDR_W-1:0];
      end
      default: begin
        address = pc_r;
      end
    endcase
  end

  // Control FSM and architectural state (PC, ACC, IR).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= {ADDR_W{1'b0}};
      acc_r   <= {DATA_W{1'b0}};
      ir_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_FETCH: begin
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_r <= readdata;
          if (jump_taken(dec_op_s, acc_r)) begin
            pc_r <= dec_s_s;
          end else begin
            pc_r <= pc_r + 12'd1;   // wraps 0xFFF -> 0x000
          end
          case (dec_op_s)
            OP_LDA, OP_ADD, OP_SUB:         state_r <= ST_EXEC;
            OP_STA, OP_JMP, OP_JGE, OP_JNE: state_r <= ST_FETCH;
            default:                        state_r <= ST_HALTED;
          endcase
        end
        ST_EXEC: begin
          case (exe_op_s)
            OP_LDA:  acc_r <= readdata;
            OP_ADD:  acc_r <= acc_r + readdata;
            OP_SUB:  acc_r <= acc_r - readdata;
            default: acc_r <= acc_r;
          endcase
          state_r <= ST_FETCH;
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mu0_delay1.sv
// Self-checking bench for cpu_mu0_delay1 with a 4096x16 one-cycle-latency
// memory model. Expected stores are queued when a program is loaded and
// popped as the CPU writes; cycle counts and strobes are checked per task.
module tb_cpu_mu0_delay1;

  logic        clk;
  logic        rst;
  logic        running;
  logic [11:0] address;
  logic        write;
  logic        read;
  logic [15:0] writedata;
  logic [15:0] readdata;

  logic [15:0] mem [0:4095];
  logic [27:0] exp_q [$];
  int          checks;
  int          errors;

  cpu_mu0_delay1 dut (
    .clk       (clk),
    .rst       (rst),
    .running   (running),
    .address   (address),
    .write     (write),
    .read      (read),
    .writedata (writedata),
    .readdata  (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, synchronous write.
  always @(posedge clk) begin
    if (write) mem[address] <= writedata;
    if (read) readdata <= mem[address];
  end

  // Protocol checks and store scoreboard, sampled away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (read && write) begin
        errors++;
        $display("FAIL protocol_rw read=%0b write=%0b required not both", read, write);
      end
      checks++;
      if (!running && (read || write)) begin
        errors++;
        $display("FAIL protocol_halted read=%0b write=%0b required 0 0", read, write);
      end
      if (write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_store addr=%h data=%h required no store", address, writedata);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          if ({address, writedata} !== e) begin
            errors++;
            $display("FAIL store addr=%h data=%h required addr=%h data=%h",
                     address, writedata, e[27:16], e[15:0]);
          end
        end
      end
    end
  end

  task automatic hold_reset();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    @(negedge clk);
  endtask

  // Release reset and count rising edges until running drops (bounded).
  task automatic run_prog(input int max_cyc, output int cycles);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while (running && cycles < max_cyc) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (running) begin
      errors++;
      $display("FAIL timeout running=%0b after %0d cycles required 0", running, cycles);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_stores pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    hold_reset();
    mem[0] = 16'h7000;
    checks++;
    if (running !== 1'b1 || read !== 1'b1 || write !== 1'b0 || address !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs run=%b rd=%b wr=%b addr=%h required 1 1 0 000",
               running, read, write, address);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (running !== 1'b1 || read !== 1'b0 || write !== 1'b0) begin
      errors++;
      $display("FAIL stp_decode run=%b rd=%b wr=%b required 1 0 0", running, read, write);
    end
    @(posedge clk);
    #1;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL stp_halt running=%b required 0", running);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (running !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
      errors++;
      $display("FAIL halt_absorbing run=%b rd=%b wr=%b required 0 0 0", running, read, write);
    end
  endtask

  task automatic test_add_store();
    int cyc;
    hold_reset();
    mem[0] = 16'h0005; mem[1] = 16'h2006; mem[2] = 16'h1007; mem[3] = 16'h7000;
    mem[5] = 16'h0003; mem[6] = 16'h0004;
    exp_q.push_back({12'h007, 16'h0007});
    run_prog(100, cyc);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL add_store_cycles got=%0d required 10", cyc);
    end
    checks++;
    if (mem[7] !== 16'h0007) begin
      errors++;
      $display("FAIL add_store_mem7 got=%h required 0007", mem[7]);
    end
  endtask

  task automatic test_countdown();
    int cyc;
    hold_reset();
    // LDA 10; SUB 11; STA 12; JNE 1; STP  with M[10]=3, M[11]=1
    mem[0] = 16'h000A; mem[1] = 16'h300B; mem[2] = 16'h100C; mem[3] = 16'h6001;
    mem[4] = 16'h7000; mem[10] = 16'h0003; mem[11] = 16'h0001;
    exp_q.push_back({12'h00C, 16'h0002});
    exp_q.push_back({12'h00C, 16'h0001});
    exp_q.push_back({12'h00C, 16'h0000});
    run_prog(10000, cyc);
    checks++;
    if (cyc != 26) begin
      errors++;
      $display("FAIL countdown_cycles got=%0d required 26", cyc);
    end
  endtask

  task automatic test_jge_sub();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      hold_reset();
      // LDA 20; JGE 5; STA 30; STP; -; STA 31; STP
      mem[0] = 16'h0014; mem[1] = 16'h5005; mem[2] = 16'h101E; mem[3] = 16'h7000;
      mem[5] = 16'h101F; mem[6] = 16'h7000;
      mem[20] = (k == 0) ? 16'h8000 : 16'h0000;
      if (k == 0) exp_q.push_back({12'h01E, 16'h8000});
      else        exp_q.push_back({12'h01F, 16'h0000});
      run_prog(100, cyc);
      checks++;
      if (cyc != 9) begin
        errors++;
        $display("FAIL jge_cycles case=%0d got=%0d required 9", k, cyc);
      end
    end
    hold_reset();
    // LDA 20 (0); SUB 21 (1); STA 22; STP
    mem[0] = 16'h0014; mem[1] = 16'h3015; mem[2] = 16'h1016; mem[3] = 16'h7000;
    mem[20] = 16'h0000; mem[21] = 16'h0001;
    exp_q.push_back({12'h016, 16'hFFFF});
    run_prog(100, cyc);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL sub_wrap_cycles got=%0d required 10", cyc);
    end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    hold_reset();
    // JNE 5 (not taken, ACC=0); LDA 20; JMP FFF; [FFF] ADD 20 -> PC wraps to 0;
    // JNE 5 now taken; STA 51; STP
    mem[0] = 16'h6005; mem[1] = 16'h0014; mem[2] = 16'h4FFF; mem[12'hFFF] = 16'h2014;
    mem[5] = 16'h1033; mem[6] = 16'h7000; mem[20] = 16'h0009;
    exp_q.push_back({12'h033, 16'h0012});
    run_prog(200, cyc);
    checks++;
    if (cyc != 16) begin
      errors++;
      $display("FAIL pc_wrap_cycles got=%0d required 16", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    hold_reset();
    mem[0] = 16'h0014; mem[1] = 16'h2014; mem[2] = 16'h101E; mem[3] = 16'h7000;
    mem[20] = 16'h0005;
    @(negedge clk);
    rst = 1'b0;
    // LDA takes 3 edges, then FETCH and DECODE of ADD: EXEC after edge 5.
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL exec_strobes rd=%b wr=%b run=%b required 0 0 1", read, write, running);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (read !== 1'b1 || address !== 12'h000 || running !== 1'b1 || write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset rd=%b addr=%h run=%b wr=%b required 1 000 1 0",
               read, address, running, write);
    end
    // Store ACC right away after restart: must be 0, not 5 or 10.
    mem[0] = 16'h1028; mem[1] = 16'h7000;
    exp_q.push_back({12'h028, 16'h0000});
    run_prog(100, cyc);
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL reset_mid_cycles got=%0d required 4", cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_add_store();
    test_countdown();
    test_jge_sub();
    test_pc_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
